// File: rtl/display_scan_if.sv
// display_scan_if: control, data and display-drive bundle for display_scan_ctrl.
`default_nettype none

interface display_scan_if #(
  parameter int N_DIG = 4
);
  logic               en;
  logic               load;
  logic [4*N_DIG-1:0] digits_in;
  logic [N_DIG-1:0]   dp_in;
  logic               load_ack;
  logic [N_DIG-1:0]   an;
  logic [6:0]         seg;
  logic               dp;
  logic               frame_done;

  modport master (
    output en, load, digits_in, dp_in,
    input  load_ack, an, seg, dp, frame_done
  );

  modport slave (
    input  en, load, digits_in, dp_in,
    output load_ack, an, seg, dp, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed common-anode 7-segment scanner with blanking gaps
// and frame-aligned double-buffered digit updates.  Rev 1.0
`default_nettype none

module display_scan_ctrl #(
  parameter int N_DIG     = 4,
  parameter int DIV_W     = 17,
  parameter int BLANK_CYC = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  display_scan_if.slave   bus
);
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [BLK_W-1:0] C_BLK_LAST = BLK_W'(BLANK_CYC - 1);
  localparam logic [DIV_W-1:0] C_PRE_LAST = {DIV_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHOW = 2'd1, S_BLANK = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [DIV_W-1:0]   r_pre, w_pre_nxt;
  logic [BLK_W-1:0]   r_blk, w_blk_nxt;
  logic [4*N_DIG-1:0] r_shadow, w_shadow_nxt, r_stage;
  logic [N_DIG-1:0]   r_shadow_dp, w_shadow_dp_nxt, r_stage_dp;
  logic               r_pending, w_pending_nxt;
  logic               w_wrap, w_swap;
  logic [N_DIG-1:0]   r_an, w_an_nxt;
  logic [6:0]         r_seg, w_seg_nxt;
  logic               r_dp, w_dp_nxt;
  logic               r_ack, r_fd;
  logic [3:0]         w_nib;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pre_nxt   = r_pre;
    w_blk_nxt   = r_blk;
    w_wrap      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en) begin
          w_state_nxt = S_SHOW;
          w_idx_nxt   = '0;
          w_pre_nxt   = '0;
        end
      end
      S_SHOW: begin
        if (r_pre == C_PRE_LAST) begin
          w_state_nxt = S_BLANK;
          w_pre_nxt   = '0;
          w_blk_nxt   = '0;
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
      S_BLANK: begin
        if (r_blk == C_BLK_LAST) begin
          w_state_nxt = S_SHOW;
          w_blk_nxt   = '0;
          if (r_idx == C_IDX_LAST) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_blk_nxt = r_blk + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!bus.en) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_pre_nxt   = '0;
      w_blk_nxt   = '0;
      w_wrap      = 1'b0;
    end
  end

  // Staged data moves to the shadow only when idle or on the frame wrap, so a
  // frame never mixes old and new digits; a load on the swap edge waits a frame.
  always_comb begin
    w_swap          = r_pending && ((r_state == S_IDLE) || w_wrap);
    w_shadow_nxt    = w_swap ? r_stage    : r_shadow;
    w_shadow_dp_nxt = w_swap ? r_stage_dp : r_shadow_dp;
    if (bus.load)
      w_pending_nxt = 1'b1;
    else if (w_swap)
      w_pending_nxt = 1'b0;
    else
      w_pending_nxt = r_pending;
  end

  // Outputs are computed from next-state values so they register on the same edge.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    w_nib     = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];
    if (w_state_nxt == S_SHOW) begin
      w_an_nxt  = ~(N_DIG'(1) << w_idx_nxt);
      w_seg_nxt = f_decode(w_nib);
      w_dp_nxt  = ~w_shadow_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pre       <= '0;
      r_blk       <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_stage     <= '0;
      r_stage_dp  <= '0;
      r_pending   <= 1'b0;
      r_an        <= '1;
      r_seg       <= 7'h7F;
      r_dp        <= 1'b1;
      r_ack       <= 1'b0;
      r_fd        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pre       <= w_pre_nxt;
      r_blk       <= w_blk_nxt;
      r_shadow    <= w_shadow_nxt;
      r_shadow_dp <= w_shadow_dp_nxt;
      if (bus.load) begin
        r_stage    <= bus.digits_in;
        r_stage_dp <= bus.dp_in;
      end
      r_pending   <= w_pending_nxt;
      r_an        <= w_an_nxt;
      r_seg       <= w_seg_nxt;
      r_dp        <= w_dp_nxt;
      r_ack       <= w_swap;
      r_fd        <= w_wrap;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.load_ack   = r_ack;
  assign bus.frame_done = r_fd;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed, table-driven check of display_scan_ctrl
// with DIV_W=4, BLANK_CYC=2, N_DIG=4 (digit = 18 clocks, frame = 72).
`default_nettype none

module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   viol   = 0;
  int   ti     = 0;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
    logic       fd;
  } vec_t;

  vec_t tbl[$];

  display_scan_if #(.N_DIG(4)) bus ();

  display_scan_ctrl #(.N_DIG(4), .DIV_W(4), .BLANK_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp, input logic e_ack, input logic e_fd);
    checks++;
    if ({bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done} !== {e_an, e_seg, e_dp, e_ack, e_fd}) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b ack=%b fd=%b, expected an=%h seg=%h dp=%b ack=%b fd=%b",
               name, bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_done,
               e_an, e_seg, e_dp, e_ack, e_fd);
    end
  endtask

  function automatic void add(input int t, input logic [3:0] an, input logic [6:0] seg,
                              input logic dp, input logic ack, input logic fd);
    vec_t v;
    v.t = t; v.an = an; v.seg = seg; v.dp = dp; v.ack = ack; v.fd = fd;
    tbl.push_back(v);
  endfunction

  initial begin
    // t counts negedges after en rises; t=1 is the first SHOW cycle of digit 0.
    add(  1, 4'hE, 7'h40, 1, 0, 0);  add( 16, 4'hE, 7'h40, 1, 0, 0);
    add( 17, 4'hF, 7'h7F, 1, 0, 0);  add( 18, 4'hF, 7'h7F, 1, 0, 0);
    add( 19, 4'hD, 7'h79, 1, 0, 0);  add( 37, 4'hB, 7'h24, 0, 0, 0);
    add( 52, 4'hB, 7'h24, 0, 0, 0);  add( 53, 4'hF, 7'h7F, 1, 0, 0);
    add( 55, 4'h7, 7'h30, 1, 0, 0);  add( 70, 4'h7, 7'h30, 1, 0, 0);
    add( 71, 4'hF, 7'h7F, 1, 0, 0);  add( 73, 4'hE, 7'h40, 1, 0, 1);
    add( 74, 4'hE, 7'h40, 1, 0, 0);
    add( 95, 4'hD, 7'h79, 1, 0, 0);  add(110, 4'hB, 7'h24, 0, 0, 0);
    add(127, 4'h7, 7'h30, 1, 0, 0);  add(144, 4'hF, 7'h7F, 1, 0, 0);
    add(145, 4'hE, 7'h00, 1, 1, 1);  add(146, 4'hE, 7'h00, 1, 0, 0);
    add(163, 4'hD, 7'h00, 1, 0, 0);  add(199, 4'h7, 7'h00, 1, 0, 0);
    add(217, 4'hE, 7'h00, 1, 0, 1);  add(235, 4'hD, 7'h00, 1, 0, 0);
    add(289, 4'hE, 7'h08, 0, 1, 1);  add(290, 4'hE, 7'h08, 0, 0, 0);
    add(307, 4'hD, 7'h12, 0, 0, 0);  add(330, 4'hB, 7'h08, 0, 0, 0);
    add(331, 4'hF, 7'h7F, 1, 0, 0);  add(332, 4'hF, 7'h7F, 1, 1, 0);
    add(333, 4'hF, 7'h7F, 1, 0, 0);  add(335, 4'hF, 7'h7F, 1, 0, 0);
    add(336, 4'hE, 7'h79, 0, 0, 0);  add(351, 4'hE, 7'h79, 0, 0, 0);
    add(352, 4'hF, 7'h7F, 1, 0, 0);

    bus.en = 1'b0; bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;

    @(negedge clk);
    check("reset_state", 4'hF, 7'h7F, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), 4'hF, 7'h7F, 1, 0, 0);
    end

    bus.load = 1'b1; bus.digits_in = 16'h3210; bus.dp_in = 4'b0100;
    @(negedge clk);
    bus.load = 1'b0;
    check("idle_load_no_ack_yet", 4'hF, 7'h7F, 1, 0, 0);
    @(negedge clk);
    check("idle_load_ack", 4'hF, 7'h7F, 1, 1, 0);
    bus.en = 1'b1;

    for (int t = 1; t <= 352; t++) begin
      @(negedge clk);
      if ($countones(~bus.an) > 1) viol++;
      if (ti < tbl.size() && tbl[ti].t == t) begin
        check($sformatf("scan_t%0d", t), tbl[ti].an, tbl[ti].seg, tbl[ti].dp, tbl[ti].ack, tbl[ti].fd);
        ti++;
      end
      case (t)
        92:  begin bus.load = 1'b1; bus.digits_in = 16'hFEDC; bus.dp_in = 4'b0000; end
        93:  bus.load = 1'b0;
        94:  begin bus.load = 1'b1; bus.digits_in = 16'h8888; bus.dp_in = 4'b0000; end
        95:  bus.load = 1'b0;
        216: begin bus.load = 1'b1; bus.digits_in = 16'h5A5A; bus.dp_in = 4'b1111; end
        217: bus.load = 1'b0;
        327: begin bus.load = 1'b1; bus.digits_in = 16'hC7E1; bus.dp_in = 4'b0001; end
        328: bus.load = 1'b0;
        330: bus.en = 1'b0;
        335: bus.en = 1'b1;
        default: ;
      endcase
    end

    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL one_hot_anode: got %0d cycles with >1 anode low, expected 0", viol);
    end

    // Asynchronous reset during BLANK, then during SHOW where the drop is visible.
    #2 rst = 1'b0;
    #1 check("async_rst_blank", 4'hF, 7'h7F, 1, 0, 0);
    @(negedge clk);
    check("held_rst", 4'hF, 7'h7F, 1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("restart_shadow_zero", 4'hE, 7'h40, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("restart_still_d0", 4'hE, 7'h40, 1, 0, 0);
    #2 rst = 1'b0;
    #1 check("async_rst_show", 4'hF, 7'h7F, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("restart_again", 4'hE, 7'h40, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
